// File: rtl/control_unit.sv
// Registered main decoder and ALU-control generator for the MIPS datapath.
// Optional build macro CU_IMM_LOGIC_EN adds ANDI/ORI decode.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] Funct,
  output logic [2:0] ALUOp,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ALUSrc,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       Jump
);

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef CU_IMM_LOGIC_EN
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
`endif

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  logic [2:0] alu_op_d, alu_op_q;
  logic       mem_to_reg_d, mem_to_reg_q;
  logic       mem_write_d, mem_write_q;
  logic       branch_d, branch_q;
  logic       alu_src_d, alu_src_q;
  logic       reg_dst_d, reg_dst_q;
  logic       reg_write_d, reg_write_q;
  logic       jump_d, jump_q;

  always_comb begin
    alu_op_d     = AluAnd;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    reg_dst_d    = 1'b0;
    reg_write_d  = 1'b0;
    jump_d       = 1'b0;
    case (opcode)
      OpRType: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
        case (Funct)
          6'b100010: alu_op_d = AluSub;
          6'b100100: alu_op_d = AluAnd;
          6'b100101: alu_op_d = AluOr;
          6'b101010: alu_op_d = AluSlt;
          // add and every unrecognised Funct fall back to ADD
          default:   alu_op_d = AluAdd;
        endcase
      end
      OpLw: begin
        alu_src_d    = 1'b1;
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
        alu_op_d     = AluAdd;
      end
      OpSw: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
        alu_op_d    = AluAdd;
      end
      OpBeq: begin
        branch_d = 1'b1;
        alu_op_d = AluSub;
      end
      OpAddi: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = AluAdd;
      end
      OpJ: begin
        jump_d = 1'b1;
      end
`ifdef CU_IMM_LOGIC_EN
      OpAndi: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = AluAnd;
      end
      OpOri: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = AluOr;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_q     <= 3'b000;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      jump_q       <= 1'b0;
    end else begin
      alu_op_q     <= alu_op_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      branch_q     <= branch_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      reg_write_q  <= reg_write_d;
      jump_q       <= jump_d;
    end
  end

  assign ALUOp    = alu_op_q;
  assign MemtoReg = mem_to_reg_q;
  assign MemWrite = mem_write_q;
  assign Branch   = branch_q;
  assign ALUSrc   = alu_src_q;
  assign RegDst   = reg_dst_q;
  assign RegWrite = reg_write_q;
  assign Jump     = jump_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit; honours CU_IMM_LOGIC_EN like the design.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] Funct;
  logic [2:0] ALUOp;
  logic       MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, Jump;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [9:0]  exp_q[$];

  control_unit u_dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .Funct    (Funct),
    .ALUOp    (ALUOp),
    .MemtoReg (MemtoReg),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUSrc   (ALUSrc),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .Jump     (Jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {ALUOp, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, Jump}
  function automatic logic [9:0] model(input logic r, input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] rop;
    if (r) return 10'b0;
    case (fn)
      6'b100000: rop = 3'b010;
      6'b100010: rop = 3'b110;
      6'b100100: rop = 3'b000;
      6'b100101: rop = 3'b001;
      6'b101010: rop = 3'b111;
      default:   rop = 3'b010;
    endcase
    case (op)
      6'b000000: return {rop, 7'b0000110};
      6'b100011: return {3'b010, 7'b1001010};
      6'b101011: return {3'b010, 7'b0101000};
      6'b000100: return {3'b110, 7'b0010000};
      6'b001000: return {3'b010, 7'b0001010};
      6'b000010: return {3'b000, 7'b0000001};
`ifdef CU_IMM_LOGIC_EN
      6'b001100: return {3'b000, 7'b0001010};
      6'b001101: return {3'b001, 7'b0001010};
`endif
      default:   return 10'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then compare the registered result against the scoreboard.
  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic [5:0] fn);
    logic [9:0] got;
    rst    = r;
    opcode = op;
    Funct  = fn;
    exp_q.push_back(model(r, op, fn));
    @(posedge clk);
    #1;
    got = {ALUOp, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, Jump};
    check(tag, got, exp_q.pop_front());
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] rfn [6];
    logic [5:0] op;
    int         excl;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b001100,
            6'b001101};
    rfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    rst = 1'b1; opcode = 6'b100011; Funct = 6'b0;
    @(negedge clk);
    step("reset_hold0", 1'b1, 6'b100011, 6'b0);
    step("reset_hold1", 1'b1, 6'b100011, 6'b0);
    step("lw_after_reset", 1'b0, 6'b100011, 6'b0);

    foreach (rfn[i]) step($sformatf("rtype_%b", rfn[i]), 1'b0, 6'b000000, rfn[i]);

    step("seq_lw",   1'b0, 6'b100011, 6'b0);
    step("seq_sw",   1'b0, 6'b101011, 6'b0);
    step("seq_beq",  1'b0, 6'b000100, 6'b0);
    step("seq_addi", 1'b0, 6'b001000, 6'b0);
    step("seq_j",    1'b0, 6'b000010, 6'b0);
    step("seq_nop",  1'b0, 6'b111111, 6'b0);

    step("sw_funct_ignored", 1'b0, 6'b101011, 6'b101010);
    step("beq_funct_ignored", 1'b0, 6'b000100, 6'b100101);

    step("j_stream0", 1'b0, 6'b000010, 6'b0);
    step("j_midreset", 1'b1, 6'b000010, 6'b0);
    step("j_resume", 1'b0, 6'b000010, 6'b0);

    step("andi", 1'b0, 6'b001100, 6'b0);
    step("ori",  1'b0, 6'b001101, 6'b0);
    step("nop_after_ori", 1'b0, 6'b010101, 6'b0);

    for (int k = 0; k < 200; k++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      step("random", ($urandom_range(0, 15) == 0), op, 6'($urandom));
      excl = int'(MemWrite) + int'(Branch) + int'(Jump);
      check("excl_mw_br_j", {9'b0, excl <= 1}, 10'd1);
      check("excl_mw_rw", {9'b0, MemWrite & RegWrite}, 10'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
